queue_param: RTL and testbench

- Parametrised successor to the team's basic synchronous queue.
- Generalises width and depth and adds a selectable read mode: registered (standard) or first-word-fall-through (FWFT).
- Adds occupancy count, programmable almost-full/almost-empty thresholds, sticky overflow/underflow error flags and a synchronous flush.
- Sits between cache/memory-hierarchy stages as the request/response buffer.

---
 rtl/queue_param.sv | 91 +++++++++
 tb/tb_queue_param.sv | 161 ++++++++++++++++
 2 files changed

// File: rtl/queue_param.sv
// Parametrised synchronous queue with registered or FWFT read,
// occupancy count, threshold flags and sticky error flags.
module queue_param #(
  parameter int DATA_WIDTH = 32,
  parameter int DEPTH      = 8,
  parameter int PTR_WIDTH  = 3,
  parameter int AF_LEVEL   = 6,
  parameter int AE_LEVEL   = 2,
  parameter bit FWFT       = 1'b0
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  flush,
  input  logic                  wr_en,
  input  logic [DATA_WIDTH-1:0] buf_in,
  input  logic                  rd_en,
  output logic [DATA_WIDTH-1:0] buf_out,
  output logic                  empty,
  output logic                  full,
  output logic                  almost_empty,
  output logic                  almost_full,
  output logic [PTR_WIDTH:0]    count,
  output logic                  overflow,
  output logic                  underflow
);

  localparam int CW = PTR_WIDTH + 1;
  localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);
  localparam logic [CW-1:0] AF_C    = CW'(AF_LEVEL);
  localparam logic [CW-1:0] AE_C    = CW'(AE_LEVEL);

  if (DEPTH < 2 || DEPTH != (1 << PTR_WIDTH) ||
      AF_LEVEL < 0 || AF_LEVEL > DEPTH ||
      AE_LEVEL < 0 || AE_LEVEL > DEPTH) begin : g_bad_param
    $error("queue_param: illegal DEPTH/PTR_WIDTH/threshold parameters");
  end

  logic [DATA_WIDTH-1:0] mem [DEPTH];
  logic [PTR_WIDTH-1:0]  wr_ptr;
  logic [PTR_WIDTH-1:0]  rd_ptr;
  logic [DATA_WIDTH-1:0] rd_q;
  logic                  push_ok;
  logic                  pop_ok;
  logic                  clr;

  always_comb begin
    empty        = (count == '0);
    full         = (count == DEPTH_C);
    almost_empty = (count <= AE_C);
    almost_full  = (count >= AF_C);
    clr          = ~rst | flush;
    push_ok      = wr_en & (~full | rd_en);
    pop_ok       = rd_en & ~empty;
  end

  // When full, wr_ptr equals rd_ptr, so a push+pop reuses the vacated slot.
  always_ff @(posedge clk) begin
    if (!clr && push_ok)
      mem[wr_ptr] <= buf_in;
  end

  always_ff @(posedge clk) begin
    if (clr) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      count     <= '0;
      rd_q      <= '0;
      overflow  <= 1'b0;
      underflow <= 1'b0;
    end else begin
      if (push_ok)
        wr_ptr <= wr_ptr + 1'b1;
      if (pop_ok) begin
        rd_ptr <= rd_ptr + 1'b1;
        rd_q   <= mem[rd_ptr];
      end
      count <= count + CW'(push_ok) - CW'(pop_ok);
      if (wr_en & full & ~rd_en)
        overflow <= 1'b1;
      if (rd_en & empty)
        underflow <= 1'b1;
    end
  end

  always_comb begin
    buf_out = rd_q;
    if (FWFT)
      buf_out = empty ? '0 : mem[rd_ptr];
  end

endmodule

// File: tb/tb_queue_param.sv
// Randomised and directed check of queue_param in both read modes
// against a queue-based reference model.
module tb_queue_param;

  logic        clk = 1'b0;
  logic        rst;
  logic        flush;
  logic        wr_en;
  logic [31:0] buf_in;
  logic        rd_en;

  logic [31:0] out_r, out_f;
  logic        empty_r, full_r, ae_r, af_r, ovf_r, udf_r;
  logic        empty_f, full_f, ae_f, af_f, ovf_f, udf_f;
  logic [3:0]  count_r, count_f;

  int n_chk  = 0;
  int n_fail = 0;

  logic [31:0] q[$];
  logic [31:0] m_out;
  logic        m_ovf;
  logic        m_udf;

  always #5 clk = ~clk;

  queue_param #(.FWFT(1'b0)) u_reg (
    .clk(clk), .rst(rst), .flush(flush),
    .wr_en(wr_en), .buf_in(buf_in), .rd_en(rd_en),
    .buf_out(out_r), .empty(empty_r), .full(full_r),
    .almost_empty(ae_r), .almost_full(af_r),
    .count(count_r), .overflow(ovf_r), .underflow(udf_r)
  );

  queue_param #(.FWFT(1'b1)) u_fwft (
    .clk(clk), .rst(rst), .flush(flush),
    .wr_en(wr_en), .buf_in(buf_in), .rd_en(rd_en),
    .buf_out(out_f), .empty(empty_f), .full(full_f),
    .almost_empty(ae_f), .almost_full(af_f),
    .count(count_f), .overflow(ovf_f), .underflow(udf_f)
  );

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)",
               tag, got, exp, $time);
    end
  endtask

  // Reference: behaviour of one clock edge from the input rules.
  task automatic model_edge();
    bit is_full, is_empty;
    is_full  = (q.size() == 8);
    is_empty = (q.size() == 0);
    if (!rst || flush) begin
      q.delete();
      m_out = '0;
      m_ovf = 1'b0;
      m_udf = 1'b0;
    end else begin
      if (wr_en && is_full && !rd_en) m_ovf = 1'b1;
      if (rd_en && is_empty) m_udf = 1'b1;
      if (rd_en && !is_empty) m_out = q.pop_front();
      if (wr_en && (!is_full || rd_en)) q.push_back(buf_in);
    end
  endtask

  task automatic check_all();
    int n;
    logic [31:0] fw;
    n  = q.size();
    fw = (n == 0) ? 32'h0 : q[0];
    chk("count_r", 32'(count_r), 32'(n));
    chk("count_f", 32'(count_f), 32'(n));
    chk("empty_r", 32'(empty_r), 32'(n == 0));
    chk("empty_f", 32'(empty_f), 32'(n == 0));
    chk("full_r",  32'(full_r),  32'(n == 8));
    chk("full_f",  32'(full_f),  32'(n == 8));
    chk("ae_r",    32'(ae_r),    32'(n <= 2));
    chk("af_r",    32'(af_r),    32'(n >= 6));
    chk("ae_f",    32'(ae_f),    32'(n <= 2));
    chk("af_f",    32'(af_f),    32'(n >= 6));
    chk("ovf_r",   32'(ovf_r),   32'(m_ovf));
    chk("udf_r",   32'(udf_r),   32'(m_udf));
    chk("ovf_f",   32'(ovf_f),   32'(m_ovf));
    chk("udf_f",   32'(udf_f),   32'(m_udf));
    chk("out_r",   out_r,        m_out);
    chk("out_f",   out_f,        fw);
  endtask

  task automatic step(input logic w, input logic [31:0] d,
                      input logic r, input logic f);
    wr_en  = w;
    buf_in = d;
    rd_en  = r;
    flush  = f;
    @(posedge clk);
    model_edge();
    #1;
    check_all();
  endtask

  initial begin
    int bias;
    m_out  = '0;
    m_ovf  = 1'b0;
    m_udf  = 1'b0;
    rst    = 1'b0;
    flush  = 1'b0;
    wr_en  = 1'b0;
    rd_en  = 1'b0;
    buf_in = '0;

    step(0, 0, 0, 0);
    step(0, 0, 0, 0);
    rst = 1'b1;
    step(0, 0, 0, 0);

    for (int i = 1; i <= 8; i++) step(1, 32'(i * 10), 0, 0);
    step(1, 90, 0, 0);
    for (int i = 0; i < 8; i++) step(0, 0, 1, 0);

    for (int i = 1; i <= 8; i++) step(1, 32'(100 + i), 0, 0);
    step(1, 140, 1, 0);
    for (int i = 0; i < 8; i++) step(0, 0, 1, 0);
    step(1, 5, 1, 0);
    step(0, 0, 1, 0);

    for (int i = 0; i < 3; i++) step(1, 32'(200 + i), 0, 0);
    for (int i = 3; i < 23; i++) step(1, 32'(200 + i), 1, 0);
    for (int i = 0; i < 3; i++) step(0, 0, 1, 0);

    step(1, 32'hA0, 0, 0);
    step(0, 0, 0, 0);
    step(0, 0, 1, 0);

    for (int i = 0; i < 5; i++) step(1, 32'(300 + i), 0, 0);
    step(1, 32'h99, 0, 1);
    step(0, 0, 0, 0);

    bias = 50;
    for (int i = 0; i < 3000; i++) begin
      if (i % 64 == 0) bias = int'($urandom_range(15, 85));
      rst = ($urandom_range(0, 299) != 0);
      step(($urandom_range(0, 99) < bias), $urandom,
           ($urandom_range(0, 99) >= bias),
           ($urandom_range(0, 99) < 2));
    end
    rst = 1'b1;
    for (int i = 0; i < 10; i++) step(0, 0, 1, 0);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
